// File: rtl/role_trace_packer.sv
`default_nettype none
// ============================================================================
// Module      : role_trace_packer
// Description : Packs a narrow trace word stream into wide AXI-Stream beats
//               (OUT_W/IN_W words per beat, little-endian lanes). It frames
//               the beats into packets of PKT_BEATS and closes partial beats
//               or open packets on an idle timeout or on flush_req. tkeep
//               marks the valid bytes of every beat.
// Ports       : aclk, areset           clock, synchronous active-high reset
//               s_axis_trace_*         input word stream (tvalid/tready/tdata)
//               flush_req              one-cycle request to close beat+packet
//               m_axis_trace_*         output beats (tvalid/tready/tdata/
//                                      tkeep/tlast)
//               pkt_cnt                packets emitted (wraps at 2^32)
//               busy                   accumulator/packet/output occupied
// Revision    : 1.0 - initial release
// ============================================================================
module role_trace_packer #(
    parameter int unsigned IN_W      = 64,
    parameter int unsigned OUT_W     = 512,
    parameter int unsigned PKT_BEATS = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_axis_trace_tvalid,
    output logic                 s_axis_trace_tready,
    input  logic [IN_W-1:0]      s_axis_trace_tdata,
    input  logic                 flush_req,
    output logic                 m_axis_trace_tvalid,
    input  logic                 m_axis_trace_tready,
    output logic [OUT_W-1:0]     m_axis_trace_tdata,
    output logic [OUT_W/8-1:0]   m_axis_trace_tkeep,
    output logic                 m_axis_trace_tlast,
    output logic [31:0]          pkt_cnt,
    output logic                 busy
);

    localparam int unsigned c_RATIO   = OUT_W / IN_W;
    localparam int unsigned c_LANE_B  = IN_W / 8;
    localparam int unsigned c_KEEP_W  = OUT_W / 8;
    localparam int unsigned c_CNT_W   = $clog2(c_RATIO + 1);
    localparam int unsigned c_BEAT_W  = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam int unsigned c_IDLE_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          c_TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL  = c_CNT_W'(c_RATIO);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(PKT_BEATS - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = c_IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // Registered state
    logic [OUT_W-1:0]    acc_q,       acc_d;
    logic [c_CNT_W-1:0]  acc_cnt_q,   acc_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q,  out_data_d;
    logic [c_KEEP_W-1:0] out_keep_q,  out_keep_d;
    logic                out_last_q,  out_last_d;
    logic [c_BEAT_W-1:0] beat_q,      beat_d;
    logic [c_IDLE_W-1:0] idle_q,      idle_d;
    logic                flush_pend_q, flush_pend_d;
    logic [31:0]         pkt_cnt_q,   pkt_cnt_d;
    logic                busy_q,      busy_d;

    // Combinational helpers
    logic                w_out_fire;
    logic                w_out_free;
    logic                w_acc_full;
    logic                w_s_ready;
    logic                w_in_fire;
    logic                w_active;
    logic                w_timeout;
    logic                w_flush;
    logic                w_last_beat;
    logic                w_load;
    logic [OUT_W-1:0]    w_merged;
    logic [c_CNT_W-1:0]  w_merged_cnt;
    logic [c_KEEP_W-1:0] w_part_keep;

    always_comb begin
        w_out_fire = out_valid_q & m_axis_trace_tready;
        // The output register can take a new beat if empty or draining now.
        w_out_free = ~out_valid_q | w_out_fire;
        w_acc_full = (acc_cnt_q == c_CNT_FULL);
        // A full accumulator that can hand off this cycle frees lane 0 for the
        // incoming word, so input only stalls when the hand-off is blocked.
        w_s_ready  = ~areset & ~flush_pend_q & (~w_acc_full | w_out_free);
        w_in_fire  = s_axis_trace_tvalid & w_s_ready;
        w_active   = (acc_cnt_q != '0) | (beat_q != '0);
        w_timeout  = c_TIMEOUT_EN & w_active & ~w_in_fire & (idle_q == c_IDLE_MAX);
        w_flush    = flush_pend_q | flush_req | w_timeout;
        w_last_beat = (beat_q == c_BEAT_LAST);
    end

    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        beat_d       = beat_q;
        w_load       = 1'b0;

        // Accumulator with the accepted word dropped into its lane.
        w_merged = acc_q;
        for (int k = 0; k < int'(c_RATIO); k++) begin
            if (w_in_fire && (acc_cnt_q == c_CNT_W'(k))) begin
                w_merged[k*IN_W +: IN_W] = s_axis_trace_tdata;
            end
        end
        w_merged_cnt = acc_cnt_q + c_CNT_W'(w_in_fire);

        // Byte mask of the lanes currently held in the accumulator.
        w_part_keep = '0;
        for (int k = 0; k < int'(c_RATIO); k++) begin
            if (c_CNT_W'(k) < acc_cnt_q) begin
                w_part_keep[k*c_LANE_B +: c_LANE_B] = '1;
            end
        end

        if (w_out_fire) begin
            out_valid_d = 1'b0;
        end

        if (w_acc_full) begin
            // Full beat parked behind a stalled output register.
            if (w_out_free) begin
                w_load     = 1'b1;
                out_data_d = acc_q;
                out_keep_d = '1;
                out_last_d = w_last_beat | w_flush;
                acc_d      = '0;
                acc_d[IN_W-1:0] = w_in_fire ? s_axis_trace_tdata : '0;
                acc_cnt_d  = c_CNT_W'(w_in_fire);
            end
        end else if (w_merged_cnt == c_CNT_FULL) begin
            // Final word of a beat accepted this cycle.
            if (w_out_free) begin
                w_load     = 1'b1;
                out_data_d = w_merged;
                out_keep_d = '1;
                out_last_d = w_last_beat | w_flush;
                acc_d      = '0;
                acc_cnt_d  = '0;
            end else begin
                acc_d      = w_merged;
                acc_cnt_d  = w_merged_cnt;
            end
        end else if (flush_pend_q && w_out_free && w_active) begin
            // Partial beat, or a null beat when the accumulator is empty:
            // unused lanes of the accumulator are always zero.
            w_load     = 1'b1;
            out_data_d = acc_q;
            out_keep_d = w_part_keep;
            out_last_d = 1'b1;
            acc_d      = '0;
            acc_cnt_d  = '0;
        end else begin
            acc_d      = w_merged;
            acc_cnt_d  = w_merged_cnt;
        end

        if (w_load) begin
            out_valid_d = 1'b1;
            beat_d      = out_last_d ? '0 : beat_q + c_BEAT_W'(1);
        end
    end

    always_comb begin
        if (w_load) begin
            flush_pend_d = 1'b0;
        end else if (flush_pend_q && !w_active) begin
            // Nothing buffered and no packet open: the flush has no effect.
            flush_pend_d = 1'b0;
        end else begin
            flush_pend_d = w_flush;
        end

        if (!c_TIMEOUT_EN || w_in_fire || w_flush || !w_active) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + c_IDLE_W'(1);
        end

        pkt_cnt_d = pkt_cnt_q + 32'(w_out_fire & out_last_q);
        busy_d    = (acc_cnt_d != '0) | (beat_d != '0) | out_valid_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            beat_q       <= '0;
            idle_q       <= '0;
            flush_pend_q <= 1'b0;
            pkt_cnt_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            beat_q       <= beat_d;
            idle_q       <= idle_d;
            flush_pend_q <= flush_pend_d;
            pkt_cnt_q    <= pkt_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign s_axis_trace_tready = w_s_ready;
    assign m_axis_trace_tvalid = out_valid_q;
    assign m_axis_trace_tdata  = out_data_q;
    assign m_axis_trace_tkeep  = out_keep_q;
    assign m_axis_trace_tlast  = out_last_q;
    assign pkt_cnt             = pkt_cnt_q;
    assign busy                = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_role_trace_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_role_trace_packer
// Description : Directed self-checking bench for role_trace_packer with
//               IN_W=64, OUT_W=512, PKT_BEATS=4, TIMEOUT=16, plus a second
//               instance with TIMEOUT=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_role_trace_packer;

    localparam int unsigned IN_W      = 64;
    localparam int unsigned OUT_W     = 512;
    localparam int unsigned PKT_BEATS = 4;
    localparam int unsigned TIMEOUT   = 16;
    localparam int unsigned KEEP_W    = OUT_W / 8;

    logic               aclk = 1'b0;
    logic               areset = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [IN_W-1:0]    s_data = '0;
    logic               flush_req = 1'b0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [OUT_W-1:0]   m_data;
    logic [KEEP_W-1:0]  m_keep;
    logic               m_last;
    logic [31:0]        pkt_cnt;
    logic               busy;

    logic               nt_s_valid = 1'b0;
    logic               nt_s_ready;
    logic [IN_W-1:0]    nt_s_data = '0;
    logic               nt_m_valid;
    logic [OUT_W-1:0]   nt_m_data;
    logic [KEEP_W-1:0]  nt_m_keep;
    logic               nt_m_last;
    logic [31:0]        nt_pkt_cnt;
    logic               nt_busy;

    int n_vec = 0;
    int n_err = 0;

    logic [OUT_W-1:0]  q_data[$];
    logic [KEEP_W-1:0] q_keep[$];
    logic              q_last[$];

    always #5 aclk = ~aclk;

    role_trace_packer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .PKT_BEATS(PKT_BEATS), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .aclk(aclk), .areset(areset),
        .s_axis_trace_tvalid(s_valid), .s_axis_trace_tready(s_ready),
        .s_axis_trace_tdata(s_data), .flush_req(flush_req),
        .m_axis_trace_tvalid(m_valid), .m_axis_trace_tready(m_ready),
        .m_axis_trace_tdata(m_data), .m_axis_trace_tkeep(m_keep),
        .m_axis_trace_tlast(m_last), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    role_trace_packer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .PKT_BEATS(PKT_BEATS), .TIMEOUT(0)
    ) u_nt (
        .aclk(aclk), .areset(areset),
        .s_axis_trace_tvalid(nt_s_valid), .s_axis_trace_tready(nt_s_ready),
        .s_axis_trace_tdata(nt_s_data), .flush_req(1'b0),
        .m_axis_trace_tvalid(nt_m_valid), .m_axis_trace_tready(1'b1),
        .m_axis_trace_tdata(nt_m_data), .m_axis_trace_tkeep(nt_m_keep),
        .m_axis_trace_tlast(nt_m_last), .pkt_cnt(nt_pkt_cnt), .busy(nt_busy)
    );

    // Inputs change #1 after posedge, so the mid-cycle view shows exactly
    // the handshakes that complete at the next posedge.
    always @(negedge aclk) begin
        if (!areset && m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_keep.push_back(m_keep);
            q_last.push_back(m_last);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, actual=expired required=finished");
        $fatal(1);
    end

    function automatic logic [OUT_W-1:0] make_beat(input logic [IN_W-1:0] base, input int n);
        logic [OUT_W-1:0] b;
        b = '0;
        for (int k = 0; k < n; k++) b[k*IN_W +: IN_W] = base + IN_W'(k);
        return b;
    endfunction

    task automatic do_reset();
        s_valid    = 1'b0;
        flush_req  = 1'b0;
        nt_s_valid = 1'b0;
        areset     = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        q_data.delete();
        q_keep.delete();
        q_last.delete();
    endtask

    task automatic send_word(input logic [IN_W-1:0] w);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        @(negedge aclk);
        while (!s_ready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (!s_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_word: tready actual=%0b required=1 for word %0h", s_ready, w);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_beats(input int n, input int bound);
        int c;
        c = 0;
        while (q_data.size() < n && c < bound) begin
            @(posedge aclk);
            #1;
            c++;
        end
        n_vec++;
        if (q_data.size() < n) begin
            n_err++;
            $display("FAIL wait_beats: beats actual=%0d required=%0d", q_data.size(), n);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        n_vec++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_tready: actual=%0b required=0", s_ready); end
        n_vec++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: actual=%0b required=0", m_valid); end
        n_vec++;
        if (m_data !== '0) begin n_err++; $display("FAIL rst_tdata: actual=%0h required=0", m_data); end
        n_vec++;
        if (m_keep !== '0) begin n_err++; $display("FAIL rst_tkeep: actual=%0h required=0", m_keep); end
        n_vec++;
        if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_tlast: actual=%0b required=0", m_last); end
        n_vec++;
        if (pkt_cnt !== 32'd0) begin n_err++; $display("FAIL rst_pkt_cnt: actual=%0d required=0", pkt_cnt); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: actual=%0b required=0", busy); end
        areset = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) send_word(IN_W'(i));
        s_valid = 1'b0;
        wait_beats(4, 30);
        if (q_data.size() < 4) return;
        for (int b = 0; b < 4; b++) begin
            n_vec++;
            if (q_data[b] !== make_beat(IN_W'(8 * b), 8)) begin
                n_err++;
                $display("FAIL stream_data beat %0d: actual=%0h required=%0h", b, q_data[b], make_beat(IN_W'(8 * b), 8));
            end
            n_vec++;
            if (q_keep[b] !== {KEEP_W{1'b1}}) begin
                n_err++;
                $display("FAIL stream_keep beat %0d: actual=%0h required=all ones", b, q_keep[b]);
            end
            n_vec++;
            if (q_last[b] !== (b == 3)) begin
                n_err++;
                $display("FAIL stream_last beat %0d: actual=%0b required=%0b", b, q_last[b], (b == 3));
            end
        end
        n_vec++;
        if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL stream_pkt_cnt: actual=%0d required=1", pkt_cnt); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL stream_busy_end: actual=%0b required=0", busy); end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_word(IN_W'(100 + i));
        s_valid = 1'b0;
        n_vec++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_tready_drop: actual=%0b required=0", s_ready); end
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== make_beat(IN_W'(100), 8)) begin
            n_err++;
            $display("FAIL bp_beat0_held: valid=%0b data=%0h required valid=1 data=%0h", m_valid, m_data, make_beat(IN_W'(100), 8));
        end
        repeat (3) @(posedge aclk);
        #1;
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== make_beat(IN_W'(100), 8) || m_keep !== {KEEP_W{1'b1}} || m_last !== 1'b0) begin
            n_err++;
            $display("FAIL bp_stable: valid=%0b keep=%0h last=%0b data=%0h required 1/all ones/0/%0h", m_valid, m_keep, m_last, m_data, make_beat(IN_W'(100), 8));
        end
        n_vec++;
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_tready_held: actual=%0b required=0", s_ready); end
        m_ready = 1'b1;
        wait_beats(2, 20);
        if (q_data.size() < 2) return;
        for (int b = 0; b < 2; b++) begin
            n_vec++;
            if (q_data[b] !== make_beat(IN_W'(100 + 8 * b), 8) || q_last[b] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_beat %0d: last=%0b data=%0h required last=0 data=%0h", b, q_last[b], q_data[b], make_beat(IN_W'(100 + 8 * b), 8));
            end
        end
    endtask

    task automatic test_partial_flush();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_word(IN_W'(32'hA0 + i));
        s_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL pf_busy: actual=%0b required=1", busy); end
        flush_req = 1'b1;
        @(posedge aclk);
        #1;
        flush_req = 1'b0;
        wait_beats(1, 20);
        if (q_data.size() < 1) return;
        n_vec++;
        if (q_keep[0] !== 64'h0000_0000_00FF_FFFF) begin n_err++; $display("FAIL pf_keep: actual=%0h required=ffffff", q_keep[0]); end
        n_vec++;
        if (q_last[0] !== 1'b1) begin n_err++; $display("FAIL pf_last: actual=%0b required=1", q_last[0]); end
        n_vec++;
        if (q_data[0] !== make_beat(IN_W'(32'hA0), 3)) begin
            n_err++;
            $display("FAIL pf_data: actual=%0h required=%0h", q_data[0], make_beat(IN_W'(32'hA0), 3));
        end
        n_vec++;
        if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL pf_pkt_cnt: actual=%0d required=1", pkt_cnt); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL pf_busy_end: actual=%0b required=0", busy); end
    endtask

    task automatic test_null_flush();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_word(IN_W'(32'h40 + i));
        s_valid = 1'b0;
        wait_beats(2, 20);
        flush_req = 1'b1;
        @(posedge aclk);
        #1;
        flush_req = 1'b0;
        wait_beats(3, 20);
        if (q_data.size() < 3) return;
        n_vec++;
        if (q_last[0] !== 1'b0 || q_last[1] !== 1'b0) begin
            n_err++;
            $display("FAIL nf_early_last: actual=%0b%0b required=00", q_last[0], q_last[1]);
        end
        n_vec++;
        if (q_keep[2] !== '0 || q_data[2] !== '0) begin
            n_err++;
            $display("FAIL nf_null_beat: keep=%0h data=%0h required keep=0 data=0", q_keep[2], q_data[2]);
        end
        n_vec++;
        if (q_last[2] !== 1'b1) begin n_err++; $display("FAIL nf_last: actual=%0b required=1", q_last[2]); end
        n_vec++;
        if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL nf_pkt_cnt: actual=%0d required=1", pkt_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_word(IN_W'(32'h500 + i));
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 40) begin
            @(posedge aclk);
            #1;
            n++;
        end
        n_vec++;
        if (n !== 17) begin n_err++; $display("FAIL to_latency: cycles actual=%0d required=17", n); end
        n_vec++;
        if (m_keep !== 64'h0000_00FF_FFFF_FFFF || m_last !== 1'b1) begin
            n_err++;
            $display("FAIL to_keep_last: keep=%0h last=%0b required keep=ffffffffff last=1", m_keep, m_last);
        end
        n_vec++;
        if (m_data !== make_beat(IN_W'(32'h500), 5)) begin
            n_err++;
            $display("FAIL to_data: actual=%0h required=%0h", m_data, make_beat(IN_W'(32'h500), 5));
        end
        wait_beats(1, 10);
        n_vec++;
        if (pkt_cnt !== 32'd1) begin n_err++; $display("FAIL to_pkt_cnt: actual=%0d required=1", pkt_cnt); end
    endtask

    task automatic test_timeout_disabled();
        int seen;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            nt_s_valid = 1'b1;
            nt_s_data  = IN_W'(32'h600 + i);
            @(negedge aclk);
            n_vec++;
            if (nt_s_ready !== 1'b1) begin n_err++; $display("FAIL nt_tready word %0d: actual=%0b required=1", i, nt_s_ready); end
            @(posedge aclk);
            #1;
        end
        nt_s_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge aclk);
            if (nt_m_valid) seen++;
        end
        @(posedge aclk);
        #1;
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL nt_no_beat: valid cycles actual=%0d required=0", seen); end
        n_vec++;
        if (nt_busy !== 1'b1) begin n_err++; $display("FAIL nt_busy: actual=%0b required=1", nt_busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_word(IN_W'(32'h200 + i));
        s_valid = 1'b0;
        areset  = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        n_vec++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL rm_tvalid: actual=%0b required=0", m_valid); end
        n_vec++;
        if (pkt_cnt !== 32'd0) begin n_err++; $display("FAIL rm_pkt_cnt: actual=%0d required=0", pkt_cnt); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: actual=%0b required=0", busy); end
        repeat (20) @(posedge aclk);
        #1;
        n_vec++;
        if (q_data.size() !== 0) begin n_err++; $display("FAIL rm_no_output: beats actual=%0d required=0", q_data.size()); end
        for (int i = 0; i < 8; i++) send_word(IN_W'(32'h300 + i));
        s_valid = 1'b0;
        wait_beats(1, 20);
        if (q_data.size() < 1) return;
        n_vec++;
        if (q_data[0] !== make_beat(IN_W'(32'h300), 8) || q_keep[0] !== {KEEP_W{1'b1}} || q_last[0] !== 1'b0) begin
            n_err++;
            $display("FAIL rm_fresh_beat: keep=%0h last=%0b data=%0h required all ones/0/%0h", q_keep[0], q_last[0], q_data[0], make_beat(IN_W'(32'h300), 8));
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_partial_flush();
        test_null_flush();
        test_timeout();
        test_timeout_disabled();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
